// File: rtl/enemy_fire_scheduler_pkg.sv
// Shared definitions for the enemy fire scheduler: default grid geometry,
// index-width helper, FSM state encoding and the LFSR feedback mask.
package enemy_pkg;

  localparam int unsigned N_ENEMIES_DEFAULT = 24;
  localparam int unsigned COLS_DEFAULT      = 8;

  // Galois right-shift mask for x^16 + x^14 + x^13 + x^11 + 1
  localparam int unsigned LFSR_WIDTH = 16;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    PICK,
    SCAN,
    FIRE
  } state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/enemy_fire_scheduler_if.sv
// Bundle between the enemy grid / bullet pool and the fire scheduler.
// master: the scheduler side; slave: the game side driving alive mask and retirements.
interface enemy_fire_scheduler_if
  import enemy_pkg::*;
#(
  parameter int unsigned N_ENEMIES = N_ENEMIES_DEFAULT,
  parameter int unsigned MAX_SHOTS = 2
) ();

  localparam int unsigned IDX_W  = idx_w(N_ENEMIES);
  localparam int unsigned SHOT_W = $clog2(MAX_SHOTS + 1);

  logic                 enable;
  logic [N_ENEMIES-1:0] enemy_alive;
  logic                 shot_done;
  logic [N_ENEMIES-1:0] fire_onehot;
  logic                 fire_valid;
  logic [IDX_W-1:0]     fire_id;
  logic [SHOT_W-1:0]    shots_active;

  modport master (
    input  enable, enemy_alive, shot_done,
    output fire_onehot, fire_valid, fire_id, shots_active
  );

  modport slave (
    output enable, enemy_alive, shot_done,
    input  fire_onehot, fire_valid, fire_id, shots_active
  );

endinterface

// File: rtl/enemy_fire_scheduler_lfsr_prng.sv
// Free-running Galois LFSR used as the random start-index source.
// Advances every cycle regardless of game state; OUT_W selects the low bits exposed.
module lfsr_prng #(
  parameter int unsigned       WIDTH = 16,
  parameter logic [WIDTH-1:0]  SEED  = 16'hACE1,
  parameter logic [WIDTH-1:0]  TAPS  = 16'hB400,
  parameter int unsigned       OUT_W = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  output logic [OUT_W-1:0] q
);

  logic [WIDTH-1:0] state;

  // Shift right, folding the ejected bit back through the tap mask
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= SEED;
    end else begin
      state <= (state >> 1) ^ (state[0] ? TAPS : '0);
    end
  end

  assign q = state[OUT_W-1:0];

endmodule

// File: rtl/enemy_fire_scheduler.sv
// Enemy fire scheduler: waits FIRE_DELAY cycles, picks a pseudo-random start
// index, scans forward for an eligible enemy and issues a one-cycle fire pulse,
// keeping at most MAX_SHOTS enemy bullets in flight.
// Optional build macro: ENEMY_FIRE_BOTTOM_ROW_EN (only the front enemy of each
// column may fire); undefined means every alive enemy is eligible.
module enemy_fire_scheduler
  import enemy_pkg::*;
#(
  parameter int unsigned N_ENEMIES  = N_ENEMIES_DEFAULT,
  parameter int unsigned COLS       = COLS_DEFAULT,
  parameter int unsigned DELAY_W    = 20,
  parameter int unsigned FIRE_DELAY = 100000,
  parameter int unsigned MAX_SHOTS  = 2,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input logic clk,
  input logic reset,
  enemy_fire_scheduler_if.master bus
);

  localparam int unsigned IDX_W  = idx_w(N_ENEMIES);
  localparam int unsigned ROWS   = N_ENEMIES / COLS;
  localparam int unsigned SHOT_W = $clog2(MAX_SHOTS + 1);

  localparam logic [DELAY_W-1:0]   DELAY_LAST = DELAY_W'(FIRE_DELAY - 1);
  localparam logic [IDX_W-1:0]     PTR_LAST   = IDX_W'(N_ENEMIES - 1);
  localparam logic [IDX_W:0]       N_EXT      = (IDX_W + 1)'(N_ENEMIES);
  localparam logic [SHOT_W-1:0]    SHOT_MAX   = SHOT_W'(MAX_SHOTS);
  localparam logic [N_ENEMIES-1:0] ONE        = N_ENEMIES'(1);

  state_t               state, state_next;
  logic [DELAY_W-1:0]   count, count_next;
  logic [IDX_W-1:0]     ptr, ptr_next;
  logic [IDX_W-1:0]     probes, probes_next;
  logic [IDX_W-1:0]     lfsr_low;
  logic [IDX_W:0]       raw_ext;
  logic [IDX_W-1:0]     start_idx;
  logic [N_ENEMIES-1:0] eligible;
  logic                 terminal, room, hit, fire_sel;

  logic                 fire_valid_q;
  logic [N_ENEMIES-1:0] fire_onehot_q;
  logic [IDX_W-1:0]     fire_id_q;
  logic [SHOT_W-1:0]    shots_q;

  lfsr_prng #(
    .WIDTH (LFSR_WIDTH),
    .SEED  (LFSR_SEED),
    .TAPS  (LFSR_TAPS),
    .OUT_W (IDX_W)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_low)
  );

  // Fold out-of-range random values back into 0..N_ENEMIES-1 with one subtraction
  always_comb begin
    raw_ext = {1'b0, lfsr_low};
    if (raw_ext >= N_EXT) begin
      raw_ext = raw_ext - N_EXT;
    end
    start_idx = raw_ext[IDX_W-1:0];
  end

`ifdef ENEMY_FIRE_BOTTOM_ROW_EN
  // Walk each column bottom-up; an enemy is eligible only if nothing alive sits below it
  always_comb begin : front_mask
    logic [COLS-1:0] seen;
    int unsigned     idx;
    eligible = '0;
    seen     = '0;
    idx      = 0;
    for (int unsigned ri = 0; ri < ROWS; ri++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        idx           = (ROWS - 1 - ri) * COLS + c;
        eligible[idx] = bus.enemy_alive[idx] & ~seen[c];
        seen[c]       = seen[c] | bus.enemy_alive[idx];
      end
    end
  end
`else
  // Any alive enemy may fire
  always_comb begin
    eligible = bus.enemy_alive;
  end
`endif

  // Next-state, delay counter and scan pointer; enable low overrides everything
  always_comb begin
    state_next  = state;
    count_next  = '0;
    ptr_next    = ptr;
    probes_next = probes;
    terminal    = (count == DELAY_LAST);
    room        = (shots_q < SHOT_MAX);
    hit         = eligible[ptr];

    unique case (state)
      IDLE: begin
        if (bus.enable) state_next = WAIT;
      end
      WAIT: begin
        if (terminal) begin
          if (room) state_next = PICK;
          else      count_next = count;
        end else begin
          count_next = count + 1'b1;
        end
      end
      PICK: begin
        ptr_next    = start_idx;
        probes_next = '0;
        state_next  = SCAN;
      end
      SCAN: begin
        if (hit) begin
          state_next = FIRE;
        end else begin
          ptr_next = (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
          if (probes == PTR_LAST) state_next = WAIT;
          else                    probes_next = probes + 1'b1;
        end
      end
      FIRE: begin
        state_next = WAIT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (!bus.enable) begin
      state_next = IDLE;
      count_next = '0;
    end
  end

  assign fire_sel = (state == SCAN) && (state_next == FIRE);

  // FSM state, delay counter and scan bookkeeping
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      count  <= '0;
      ptr    <= '0;
      probes <= '0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      ptr    <= ptr_next;
      probes <= probes_next;
    end
  end

  // Registered fire outputs, launched on the SCAN hit so they coincide with FIRE
  always_ff @(posedge clk) begin
    if (!reset) begin
      fire_valid_q  <= 1'b0;
      fire_onehot_q <= '0;
      fire_id_q     <= '0;
    end else begin
      fire_valid_q  <= fire_sel;
      fire_onehot_q <= fire_sel ? (ONE << ptr) : '0;
      if (fire_sel) fire_id_q <= ptr;
    end
  end

  // In-flight count: the FIRE cycle adds one, shot_done removes one; both cancel
  always_ff @(posedge clk) begin
    if (!reset) begin
      shots_q <= '0;
    end else if ((state == FIRE) && bus.shot_done) begin
      shots_q <= shots_q;
    end else if (state == FIRE) begin
      if (shots_q < SHOT_MAX) shots_q <= shots_q + 1'b1;
    end else if (bus.shot_done && (shots_q != '0)) begin
      shots_q <= shots_q - 1'b1;
    end
  end

  assign bus.fire_valid   = fire_valid_q;
  assign bus.fire_onehot  = fire_onehot_q;
  assign bus.fire_id      = fire_id_q;
  assign bus.shots_active = shots_q;

endmodule
